// File: rtl/npc_fetch_jr.sv
// Fetch PC register and IF/ID pipeline register, with the D-stage next-PC select.
// Redirects (jr/jalr, j/jal, taken branch) take effect one edge later; the delay slot is never flushed.
module npc_fetch_jr #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_F,
  input  logic [31:0] rf_rs_D,
  input  logic [31:0] pc8_E,
  input  logic [31:0] result_M,
  input  logic [31:0] result_W,
  input  logic [1:0]  bypass_rs_jr,
  input  logic        jr_D,
  input  logic        ji_D,
  input  logic        br_taken_D,
  output logic [31:0] pc_F,
  output logic [31:0] instrD,
  output logic [31:0] pc8D,
  output logic [31:0] jr_target_D,
  output logic        jr_misaligned
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
  } ifid_t;

  ifid_t       ifid;
  logic [31:0] pc_d;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] npc;

  always_comb begin
    jr_target_D = rf_rs_D;
    case (bypass_rs_jr)
      2'd0: jr_target_D = rf_rs_D;
      2'd1: jr_target_D = pc8_E;
      2'd2: jr_target_D = result_M;
      2'd3: jr_target_D = result_W;
      default: jr_target_D = rf_rs_D;
    endcase
  end

  assign jr_misaligned = jr_D && (jr_target_D[1:0] != 2'b00);

  // D-stage address is recovered from the stored link value; upper jump bits come from it, not the delay slot
  assign pc_d      = ifid.pc8 - 32'd8;
  assign br_target = pc_d + 32'd4 + {{14{ifid.instr[15]}}, ifid.instr[15:0], 2'b00};
  assign j_target  = {pc_d[31:28], ifid.instr[25:0], 2'b00};

  always_comb begin
    npc = pc_F + 32'(PC_STEP);
    if (jr_D)            npc = jr_target_D;
    else if (ji_D)       npc = j_target;
    else if (br_taken_D) npc = br_target;
  end

  // A stalled cycle drops the redirect; D re-evaluates it next cycle with fresh forwarding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_F      <= PC_RESET;
      ifid.instr <= 32'd0;
      ifid.pc8   <= PC_RESET + 32'd4;
    end else if (!stall) begin
      pc_F      <= npc;
      ifid.instr <= instr_F;
      ifid.pc8   <= pc_F + 32'd8;
    end
  end

  assign instrD = ifid.instr;
  assign pc8D   = ifid.pc8;

endmodule
